// File: rtl/cmd_uart_rcv.sv
// cmd_uart_rcv: 8N1 UART receiver for the follower command path.
// Samples each bit at mid-bit from a two-flop synchronised RX. It presents the byte on rx_data
// with a sticky rdy, a one-cycle frm_err pulse, and a sticky ovr_err.
module cmd_uart_rcv #(
    parameter int unsigned BAUD_CNT = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [15:0] FullLoad = 16'(BAUD_CNT - 32'd1);
    localparam logic [15:0] HalfLoad = 16'((BAUD_CNT >> 1) - 32'd1);

    state_e      state_q;
    logic [15:0] baud_q;
    logic [3:0]  bit_q;
    logic [7:0]  shift_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic        sample;

    // Mid-bit sample point: the baud down-counter has run out.
    assign sample = (baud_q == 16'd0);

    // Two-flop synchroniser for the asynchronous RX line; resets to the idle (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM, baud/bit counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            shift_q <= 8'h00;
            rx_data <= 8'h00;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            frm_err <= 1'b0;

            // Consumer acknowledge; a coincident byte completion below overrides it.
            if (clr_rdy) begin
                rdy     <= 1'b0;
                ovr_err <= 1'b0;
            end

            // Idle: arm a half-bit delay on the start edge. Otherwise reload on every sample.
            if (state_q == StIdle) begin
                if (!rx_s_q) begin
                    baud_q <= HalfLoad;
                end else if (baud_q != 16'd0) begin
                    baud_q <= baud_q - 16'd1;
                end
            end else begin
                baud_q <= sample ? FullLoad : baud_q - 16'd1;
            end

            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (sample) begin
                        // A high line at mid-start is a glitch: drop it silently.
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            bit_q   <= 4'd0;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (sample) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (sample) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        state_q <= StIdle;
                        if (rx_s_q) begin
                            rx_data <= shift_q;
                            rdy     <= 1'b1;
                            if (rdy && !clr_rdy) begin
                                ovr_err <= 1'b1;
                            end
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
